// File: rtl/nios2_button_pio.sv
// Avalon-MM input PIO: synchronizes push-button inputs, optionally debounces them,
// captures selected edges into a write-1-to-clear register and raises a masked level IRQ.
module nios2_button_pio #(
   parameter int WIDTH           = 8,
   parameter int EDGE_TYPE       = 0,
   parameter int DEBOUNCE_CYCLES = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   logic [WIDTH-1:0] sync1_reg;
   logic [WIDTH-1:0] sync2_reg;
   logic [WIDTH-1:0] filt;
   logic [WIDTH-1:0] filt_d_reg;
   logic [WIDTH-1:0] edge_sel;
   logic [WIDTH-1:0] mask_reg;
   logic [WIDTH-1:0] edgecap_reg;
   logic [WIDTH-1:0] clr_bits;
   logic             wr_en;
   logic             unused_wdata;

   // Bits of writedata above WIDTH are intentionally ignored.
   assign unused_wdata = ^writedata;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_reg <= '0;
         sync2_reg <= '0;
      end else begin
         sync1_reg <= in_port;
         sync2_reg <= sync1_reg;
      end
   end

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_bypass
         assign filt = sync2_reg;
      end else begin : g_debounce
         localparam int CW = (DEBOUNCE_CYCLES + 1 > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
         for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic [CW-1:0] cnt_reg;
            logic          filt_reg;

            // The filtered bit follows only after DEBOUNCE_CYCLES consecutive mismatches.
            always_ff @(posedge clk or posedge reset) begin
               if (reset) begin
                  cnt_reg  <= '0;
                  filt_reg <= 1'b0;
               end else if (sync2_reg[gi] == filt_reg) begin
                  cnt_reg <= '0;
               end else if (cnt_reg == CW'(DEBOUNCE_CYCLES - 1)) begin
                  filt_reg <= sync2_reg[gi];
                  cnt_reg  <= '0;
               end else begin
                  cnt_reg <= cnt_reg + CW'(1);
               end
            end

            assign filt[gi] = filt_reg;
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) filt_d_reg <= '0;
      else       filt_d_reg <= filt;
   end

   always_comb begin
      edge_sel = '0;
      case (EDGE_TYPE)
         0:       edge_sel = filt & ~filt_d_reg;
         1:       edge_sel = ~filt & filt_d_reg;
         default: edge_sel = filt ^ filt_d_reg;
      endcase
   end

   assign wr_en    = chipselect & ~write_n;
   assign clr_bits = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mask_reg    <= '0;
         edgecap_reg <= '0;
      end else begin
         if (wr_en && address == 2'd2)
            mask_reg <= writedata[WIDTH-1:0];
         // A new edge wins over a simultaneous clear of the same bit.
         edgecap_reg <= (edgecap_reg & ~clr_bits) | edge_sel;
      end
   end

   always_comb begin
      readdata = '0;
      if (chipselect) begin
         case (address)
            2'd0:    readdata[WIDTH-1:0] = filt;
            2'd2:    readdata[WIDTH-1:0] = mask_reg;
            2'd3:    readdata[WIDTH-1:0] = edgecap_reg;
            default: readdata = '0;
         endcase
      end
   end

   assign irq = |(edgecap_reg & mask_reg);

endmodule

// File: tb/tb_nios2_button_pio.sv
// Directed bench for nios2_button_pio: four instances cover rising, falling,
// any-edge capture and a 4-cycle debounce configuration.
module tb_nios2_button_pio;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  address;
   logic [3:0]  cs;
   logic        write_n;
   logic [31:0] writedata;
   logic [7:0]  in_p   [4];
   logic [31:0] rd_bus [4];
   logic        irq_v  [4];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   nios2_button_pio #(.WIDTH(8), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(0)) u_rise (
      .clk(clk), .reset(reset), .address(address), .chipselect(cs[0]), .write_n(write_n),
      .writedata(writedata), .in_port(in_p[0]), .readdata(rd_bus[0]), .irq(irq_v[0]));
   nios2_button_pio #(.WIDTH(8), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(0)) u_fall (
      .clk(clk), .reset(reset), .address(address), .chipselect(cs[1]), .write_n(write_n),
      .writedata(writedata), .in_port(in_p[1]), .readdata(rd_bus[1]), .irq(irq_v[1]));
   nios2_button_pio #(.WIDTH(8), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(0)) u_any (
      .clk(clk), .reset(reset), .address(address), .chipselect(cs[2]), .write_n(write_n),
      .writedata(writedata), .in_port(in_p[2]), .readdata(rd_bus[2]), .irq(irq_v[2]));
   nios2_button_pio #(.WIDTH(8), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(4)) u_deb (
      .clk(clk), .reset(reset), .address(address), .chipselect(cs[3]), .write_n(write_n),
      .writedata(writedata), .in_port(in_p[3]), .readdata(rd_bus[3]), .irq(irq_v[3]));

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input int sel, input logic [1:0] a, input logic [31:0] d);
      @(posedge clk);
      #1;
      cs[sel]   = 1'b1;
      address   = a;
      write_n   = 1'b0;
      writedata = d;
      @(posedge clk);
      #1;
      cs        = '0;
      write_n   = 1'b1;
      writedata = '0;
      $display("write inst=%0d addr=%0d data=%h", sel, a, d);
   endtask

   task automatic rd(input int sel, input logic [1:0] a, output logic [31:0] d);
      cs[sel] = 1'b1;
      address = a;
      write_n = 1'b1;
      #1;
      d = rd_bus[sel];
      cs = '0;
      $display("read  inst=%0d addr=%0d data=%h", sel, a, d);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp_v);
      end
   endtask

   task automatic test_reset;
      logic [31:0] d;
      in_p[0] = 8'hFF;
      wr(0, 2'd2, 32'hFF);
      tick(4);
      n_checks++;
      if (irq_v[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_reset_irq: got %b expected 1", irq_v[0]);
      end
      // Assert reset mid-cycle and look at outputs before any clock edge.
      @(posedge clk);
      #5;
      reset   = 1'b1;
      cs[0]   = 1'b1;
      address = 2'd2;
      #1;
      n_checks++;
      if (rd_bus[0] !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_async_mask: got %h expected 0", rd_bus[0]);
      end
      n_checks++;
      if (irq_v[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_async_irq: got %b expected 0", irq_v[0]);
      end
      cs = '0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      tick(1);
      rd(0, 2'd0, d);
      chk("reset_data_c1", d, 32'h0);
      tick(1);
      rd(0, 2'd0, d);
      chk("reset_data_c2", d, 32'hFF);
      rd(0, 2'd2, d);
      chk("reset_mask", d, 32'h0);
      rd(0, 2'd3, d);
      chk("reset_ec_before", d, 32'h0);
      tick(1);
      rd(0, 2'd3, d);
      chk("reset_ec_after", d, 32'hFF);
      n_checks++;
      if (irq_v[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_irq_masked: got %b expected 0", irq_v[0]);
      end
      address = 2'd0;
      #1;
      n_checks++;
      if (rd_bus[0] !== 32'h0) begin
         n_fail++;
         $display("FAIL cs_low_read: got %h expected 0", rd_bus[0]);
      end
   endtask

   task automatic settle_all;
      for (int i = 0; i < 4; i++) in_p[i] = 8'h00;
      tick(12);
      for (int i = 0; i < 4; i++) wr(i, 2'd3, 32'hFF);
   endtask

   task automatic test_rising;
      logic [31:0] d;
      wr(0, 2'd2, 32'h01);
      in_p[0][0] = 1'b1;
      tick(2);
      rd(0, 2'd3, d);
      chk("rise_ec_c2", d, 32'h0);
      chk("rise_irq_c2", {31'h0, irq_v[0]}, 32'h0);
      tick(1);
      rd(0, 2'd3, d);
      chk("rise_ec_c3", d, 32'h01);
      chk("rise_irq_c3", {31'h0, irq_v[0]}, 32'h1);
      wr(0, 2'd3, 32'h01);
      rd(0, 2'd3, d);
      chk("rise_ec_cleared", d, 32'h0);
      chk("rise_irq_cleared", {31'h0, irq_v[0]}, 32'h0);
      wr(0, 2'd0, 32'hFF);
      rd(0, 2'd0, d);
      chk("data_ro", d, 32'h01);
      wr(0, 2'd1, 32'hFF);
      rd(0, 2'd1, d);
      chk("reserved_zero", d, 32'h0);
   endtask

   task automatic test_fall_any;
      logic [31:0] d;
      in_p[1][3] = 1'b1;
      in_p[2][3] = 1'b1;
      tick(5);
      rd(1, 2'd3, d);
      chk("fall_on_rise", d, 32'h0);
      rd(2, 2'd3, d);
      chk("any_on_rise", d, 32'h08);
      wr(2, 2'd3, 32'h08);
      rd(2, 2'd3, d);
      chk("any_cleared", d, 32'h0);
      in_p[1][3] = 1'b0;
      in_p[2][3] = 1'b0;
      tick(5);
      rd(1, 2'd3, d);
      chk("fall_on_fall", d, 32'h08);
      rd(2, 2'd3, d);
      chk("any_on_fall", d, 32'h08);
   endtask

   task automatic test_w1c;
      logic [31:0] d;
      in_p[0] = 8'h07;
      tick(5);
      rd(0, 2'd3, d);
      chk("w1c_setup", d, 32'h06);
      wr(0, 2'd3, 32'h02);
      rd(0, 2'd3, d);
      chk("w1c_select", d, 32'h04);
      in_p[0][2] = 1'b0;
      tick(5);
      // Rising edge on bit 2 lands on the same clock that applies the clear.
      in_p[0][2] = 1'b1;
      tick(1);
      wr(0, 2'd3, 32'h04);
      rd(0, 2'd3, d);
      chk("w1c_collision", d, 32'h04);
      wr(0, 2'd3, 32'h04);
      rd(0, 2'd3, d);
      chk("w1c_plain_clear", d, 32'h0);
   endtask

   task automatic test_debounce;
      logic [31:0] d;
      in_p[3][1] = 1'b1;
      tick(3);
      in_p[3][1] = 1'b0;
      tick(10);
      rd(3, 2'd0, d);
      chk("deb_glitch_data", d, 32'h0);
      rd(3, 2'd3, d);
      chk("deb_glitch_ec", d, 32'h0);
      in_p[3][1] = 1'b1;
      tick(5);
      rd(3, 2'd0, d);
      chk("deb_data_c5", d, 32'h0);
      tick(1);
      rd(3, 2'd0, d);
      chk("deb_data_c6", d, 32'h02);
      rd(3, 2'd3, d);
      chk("deb_ec_c6", d, 32'h0);
      tick(1);
      rd(3, 2'd3, d);
      chk("deb_ec_c7", d, 32'h02);
      tick(3);
      in_p[3][1] = 1'b0;
   endtask

   task automatic test_mask;
      logic [31:0] d;
      wr(0, 2'd2, 32'h00);
      wr(0, 2'd3, 32'hFF);
      in_p[0][7] = 1'b1;
      tick(5);
      rd(0, 2'd3, d);
      chk("mask_ec", d, 32'h80);
      chk("mask_irq_off", {31'h0, irq_v[0]}, 32'h0);
      wr(0, 2'd2, 32'h80);
      chk("mask_irq_on", {31'h0, irq_v[0]}, 32'h1);
      wr(0, 2'd2, 32'h00);
      chk("mask_irq_off2", {31'h0, irq_v[0]}, 32'h0);
      rd(0, 2'd3, d);
      chk("mask_ec_kept", d, 32'h80);
   endtask

   initial begin
      reset     = 1'b1;
      address   = '0;
      cs        = '0;
      write_n   = 1'b1;
      writedata = '0;
      for (int i = 0; i < 4; i++) in_p[i] = 8'h00;
      tick(3);
      reset = 1'b0;
      tick(3);
      test_reset();
      settle_all();
      test_rising();
      test_fall_any();
      test_w1c();
      test_debounce();
      test_mask();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
